param_sram_clr: RTL

- Parametrised single-port synchronous SRAM model for the DTW front end. Successor to the fixed 1024x32 word store.
- Adds configurable width, depth and read latency, split data buses, byte-write enables, and a read-valid strobe.
- Adds a hardware range-clear engine that zeroes a word range between DTW passes, replacing the testbench clear loop.
- Sits between TOP's memory port and the bench/SoC interconnect.

---
 rtl/param_sram_clr_pkg.sv | 21 ++
 rtl/param_sram_clr_if.sv | 40 ++++
 rtl/param_sram_clr_fsm.sv | 86 ++++++++
 rtl/param_sram_clr.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/param_sram_clr_pkg.sv
// Shared types and helpers for the parametrised SRAM with range-clear engine.
// Optional parity storage is enabled by defining SRAM_PARITY_EN.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SRAM_AW = 10;
    localparam int unsigned BYTES   = SRAM_DW / 8;
    localparam int unsigned DEPTH   = 2 ** SRAM_AW;

    // Even parity: the stored bit makes the byte plus parity an even count of ones.
    function automatic logic parity_byte(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/param_sram_clr_if.sv
// Host bus and clear-engine control of the parametrised SRAM.
// SRAM_PARITY_EN adds the parity_err response signal.
interface param_sram_clr_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 10
);
    logic            cs_n;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic            clr_req;
    logic [AW-1:0]   clr_base;
    logic [AW:0]     clr_len;
    logic            clr_busy;
    logic            clr_done;
`ifdef SRAM_PARITY_EN
    logic            parity_err;

    modport master (
        output cs_n, wr, addr, wdata, be, clr_req, clr_base, clr_len,
        input  rdata, rvalid, clr_busy, clr_done, parity_err
    );
    modport slave (
        input  cs_n, wr, addr, wdata, be, clr_req, clr_base, clr_len,
        output rdata, rvalid, clr_busy, clr_done, parity_err
    );
`else
    modport master (
        output cs_n, wr, addr, wdata, be, clr_req, clr_base, clr_len,
        input  rdata, rvalid, clr_busy, clr_done
    );
    modport slave (
        input  cs_n, wr, addr, wdata, be, clr_req, clr_base, clr_len,
        output rdata, rvalid, clr_busy, clr_done
    );
`endif
endinterface

// File: rtl/param_sram_clr_fsm.sv
// Range-clear engine: walks ptr from clr_base for clr_len words, one zero-write per cycle.
module sram_clr_fsm
    import sram_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic [AW-1:0] clr_base,
    input  logic [AW:0]   clr_len,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we_c,
    output logic [AW-1:0] clr_addr_c
);
    localparam int unsigned CW = AW + 1;

    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next state, pointer/count update and clear write strobe.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        clr_we_c   = 1'b0;
        clr_addr_c = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    if (clr_len != '0) begin
                        ptr_d   = clr_base;
                        cnt_d   = clr_len;
                        state_d = CLEAR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                clr_we_c = 1'b1;
                ptr_d    = ptr_q + AW'(1);
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: rtl/param_sram_clr.sv
// Parametrised single-port SRAM with byte enables, RD_LAT-cycle read pipeline
// and a hardware range-clear engine. Define SRAM_PARITY_EN for per-byte parity.
module param_sram_clr
    import sram_pkg::*;
#(
    parameter int unsigned DW     = SRAM_DW,
    parameter int unsigned AW     = SRAM_AW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    param_sram_clr_if.slave bus
);
    localparam int unsigned NBYTES = DW / 8;
    localparam int unsigned NDEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [NDEPTH];

    logic          clr_busy;
    logic          clr_done;
    logic          clr_we_c;
    logic [AW-1:0] clr_addr_c;
    logic          host_wr_c;
    logic          host_rd_c;

    logic          rv1_q, rv1_d;
    logic [DW-1:0] rd1_q, rd1_d;

    sram_clr_fsm #(.AW(AW)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (bus.clr_req),
        .clr_base   (bus.clr_base),
        .clr_len    (bus.clr_len),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clr_we_c   (clr_we_c),
        .clr_addr_c (clr_addr_c)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // Host accesses are dropped while the clear engine owns the array.
    always_comb begin
        host_wr_c = 1'b0;
        host_rd_c = 1'b0;
        if (!bus.cs_n && !clr_busy) begin
            host_wr_c = bus.wr;
            host_rd_c = !bus.wr;
        end
    end

    // Array write port: clear engine zero-writes or host byte-masked writes.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[clr_addr_c] <= '0;
        end else if (host_wr_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (bus.be[i]) begin
                    mem_q[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: capture the addressed word; data holds between reads.
    always_comb begin
        rv1_d = host_rd_c;
        rd1_d = rd1_q;
        if (host_rd_c) begin
            rd1_d = mem_q[bus.addr];
        end
    end

    // First read stage registers, flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            rv1_q <= rv1_d;
            rd1_q <= rd1_d;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NBYTES-1:0] par_q [NDEPTH];
    logic              perr_c;
    logic              pe1_q, pe1_d;

    // Parity store tracks the data array byte for byte; clear writes parity 0.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            par_q[clr_addr_c] <= '0;
        end else if (host_wr_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (bus.be[i]) begin
                    par_q[bus.addr][i] <= parity_byte(bus.wdata[8*i +: 8]);
                end
            end
        end
    end

    // Any byte whose recomputed parity disagrees with the stored bit flags an error.
    always_comb begin
        perr_c = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (parity_byte(mem_q[bus.addr][8*i +: 8]) != par_q[bus.addr][i]) begin
                perr_c = 1'b1;
            end
        end
        pe1_d = host_rd_c & perr_c;
    end

    // Parity error travels with the first read stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe1_q <= 1'b0;
        end else begin
            pe1_q <= pe1_d;
        end
    end

    // Backdoor error injection: inverts one stored data bit.
    task automatic flip_bit(input logic [AW-1:0] a, input int unsigned b);
        mem_q[a][b] <= ~mem_q[a][b];
    endtask
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          rv2_q, rv2_d;
            logic [DW-1:0] rd2_q, rd2_d;

            // Second read stage: forward stage-one data when it was valid.
            always_comb begin
                rv2_d = rv1_q;
                rd2_d = rd2_q;
                if (rv1_q) begin
                    rd2_d = rd1_q;
                end
            end

            // Second read stage registers, flushed by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rv2_q <= 1'b0;
                    rd2_q <= '0;
                end else begin
                    rv2_q <= rv2_d;
                    rd2_q <= rd2_d;
                end
            end

            assign bus.rvalid = rv2_q;
            assign bus.rdata  = rd2_q;

`ifdef SRAM_PARITY_EN
            logic pe2_q;

            // Parity error follows the second read stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pe2_q <= 1'b0;
                end else begin
                    pe2_q <= pe1_q;
                end
            end

            assign bus.parity_err = pe2_q;
`endif
        end else begin : g_lat1
            assign bus.rvalid = rv1_q;
            assign bus.rdata  = rd1_q;
`ifdef SRAM_PARITY_EN
            assign bus.parity_err = pe1_q;
`endif
        end
    endgenerate

endmodule
